// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request controller: floor geometry,
// next_stage encoding, door timing default, controller states and the
// target-floor selection helper.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W = 2;
    localparam int DOOR_TIME_DEF = 10;

    // next_stage = {valid, floor}; all-zero means "no request"
    localparam int NS_VALID = 2;
    localparam logic [2:0] NS_NONE = 3'b000;

    // seconds counter saturates here instead of wrapping
    localparam logic [3:0] CLOCK_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_MOVING   = 2'd2,
        ST_DOOR     = 2'd3
    } ctrl_state_e;

    // Nearest pending floor in the preferred direction, falling back to the
    // nearest in the opposite direction. Within one direction every candidate
    // has a distinct distance, so no tie can arise between them.
    function automatic logic [2:0] pick_target(
        input logic [NUM_FLOORS-1:0] pend,
        input logic [FLOOR_W-1:0]    here,
        input logic                  up
    );
        logic [2:0] up_cand;
        logic [2:0] dn_cand;
        up_cand = NS_NONE;
        dn_cand = NS_NONE;
        // scanning downward leaves the lowest floor above 'here'
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pend[f] && (f > int'(here))) begin
                up_cand = {1'b1, 2'(f)};
            end
        end
        // scanning upward leaves the highest floor below 'here'
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pend[f] && (f < int'(here))) begin
                dn_cand = {1'b1, 2'(f)};
            end
        end
        if (up) begin
            return up_cand[NS_VALID] ? up_cand : dn_cand;
        end
        return dn_cand[NS_VALID] ? dn_cand : up_cand;
    endfunction

endpackage

// File: rtl/elevator_sec_counter.sv
// Saturating seconds counter with a clear handshake. A clear request wipes
// the count (a coincident tick is dropped) and is acknowledged once per
// rising edge of reset_clock.
module elevator_sec_counter
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       reset_clock,
    output logic [3:0] actual_clock,
    output logic       DoneResetClock
);

    logic clear_d_reg;

    // count seconds, clear on request, acknowledge each new clear request
    always_ff @(posedge clk) begin
        if (!reset) begin
            actual_clock   <= 4'd0;
            DoneResetClock <= 1'b0;
            clear_d_reg    <= 1'b0;
        end else begin
            clear_d_reg    <= reset_clock;
            DoneResetClock <= reset_clock & ~clear_d_reg;
            if (reset_clock) begin
                actual_clock <= 4'd0;
            end else if (tick_1s && (actual_clock != CLOCK_MAX)) begin
                actual_clock <= actual_clock + 4'd1;
            end
        end
    end

endmodule

// File: rtl/elevator_req_ctrl.sv
// Elevator request controller: latches hall calls, opens the door on
// arrival at a called floor, proposes the next target while the door is
// open, and commands restarts toward outstanding calls.
module elevator_req_ctrl
    import elevator_pkg::*;
#(
    parameter int DOOR_TIME = DOOR_TIME_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic [3:0] floor_btn,
    input  logic       reset_clock,
    input  logic       Delay,
    input  logic       FR_Delay,
    input  logic [1:0] Actual_Stage,
    input  logic       UD_Answer,
    input  logic       STOP,
    output logic [3:0] actual_clock,
    output logic       DoneResetClock,
    output logic       DoneDelay,
    output logic       DoneFRDelay,
    output logic [2:0] next_stage,
    output logic       OC_Request,
    output logic       UD_Request,
    output logic       NO_STOP,
    output logic [3:0] pending
);

    ctrl_state_e state_reg, state_next;
    logic        delay_d_reg, fr_d_reg;
    logic        delay_edge, fr_edge;
    logic [3:0]  here_mask;
    logic [3:0]  clr_mask;
    logic        others_pending, any_above;
    logic [2:0]  target;
    logic [3:0]  pending_next;
    logic [2:0]  ns_next;
    logic        oc_next, ud_next, nostop_next;

    elevator_sec_counter u_sec_counter (
        .clk            (clk),
        .reset          (reset),
        .tick_1s        (tick_1s),
        .reset_clock    (reset_clock),
        .actual_clock   (actual_clock),
        .DoneResetClock (DoneResetClock)
    );

    assign delay_edge     = Delay & ~delay_d_reg;
    assign fr_edge        = FR_Delay & ~fr_d_reg;
    assign here_mask      = 4'b0001 << Actual_Stage;
    assign others_pending = |(pending & ~here_mask);
    assign target         = pick_target(pending, Actual_Stage, UD_Answer);

    // any outstanding call strictly above the cabin decides restart direction
    always_comb begin
        any_above = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && (f > int'(Actual_Stage))) begin
                any_above = 1'b1;
            end
        end
    end

    // controller next-state; arrival and proposal-consumed notices override state actions
    always_comb begin
        state_next  = state_reg;
        oc_next     = OC_Request;
        ud_next     = UD_Request;
        nostop_next = NO_STOP;
        ns_next     = next_stage;
        clr_mask    = 4'b0000;

        case (state_reg)
            ST_IDLE: begin
                if (others_pending) begin
                    ud_next     = any_above;
                    nostop_next = 1'b1;
                    oc_next     = 1'b0;
                    state_next  = ST_DISPATCH;
                end else if (|(pending & here_mask)) begin
                    // call for the floor we already stand at: just absorb it
                    clr_mask = here_mask;
                    oc_next  = 1'b1;
                end
            end
            ST_DISPATCH: begin
                nostop_next = 1'b1;
                oc_next     = 1'b0;
                if (!STOP) begin
                    nostop_next = 1'b0;
                    state_next  = ST_MOVING;
                end
            end
            ST_MOVING: begin
                oc_next     = 1'b0;
                nostop_next = 1'b0;
                ns_next     = NS_NONE;
            end
            ST_DOOR: begin
                oc_next = 1'b1;
                // proposals stop once the door hold time is used up
                if ((int'(actual_clock) < DOOR_TIME) && target[NS_VALID]) begin
                    ns_next = target;
                end
                if (STOP) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (fr_edge) begin
            ns_next = NS_NONE;
        end

        if (delay_edge) begin
            if (pending[Actual_Stage] || floor_btn[Actual_Stage]) begin
                clr_mask   = here_mask;
                oc_next    = 1'b1;
                state_next = ST_DOOR;
            end else begin
                oc_next    = 1'b0;
                state_next = ST_MOVING;
            end
        end

        // a press in the same cycle as service re-arms the call
        pending_next = (pending & ~clr_mask) | floor_btn;
    end

    // register controller state, outputs and handshake acknowledges
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            pending     <= 4'b0000;
            next_stage  <= NS_NONE;
            OC_Request  <= 1'b1;
            UD_Request  <= 1'b1;
            NO_STOP     <= 1'b0;
            DoneDelay   <= 1'b0;
            DoneFRDelay <= 1'b0;
            delay_d_reg <= 1'b0;
            fr_d_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending     <= pending_next;
            next_stage  <= ns_next;
            OC_Request  <= oc_next;
            UD_Request  <= ud_next;
            NO_STOP     <= nostop_next;
            DoneDelay   <= delay_edge;
            DoneFRDelay <= fr_edge;
            delay_d_reg <= Delay;
            fr_d_reg    <= FR_Delay;
        end
    end

endmodule

// File: tb/tb_elevator_req_ctrl.sv
// Directed bench for elevator_req_ctrl. Expected values are queued when the
// stimulus is applied and compared after the DUT has had time to respond.
module tb_elevator_req_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1s;
    logic [3:0] floor_btn;
    logic       reset_clock;
    logic       Delay;
    logic       FR_Delay;
    logic [1:0] Actual_Stage;
    logic       UD_Answer;
    logic       STOP;
    logic [3:0] actual_clock;
    logic       DoneResetClock;
    logic       DoneDelay;
    logic       DoneFRDelay;
    logic [2:0] next_stage;
    logic       OC_Request;
    logic       UD_Request;
    logic       NO_STOP;
    logic [3:0] pending;

    localparam int S_CLK = 0, S_DRC = 1, S_DD = 2, S_DFR = 3, S_NS = 4;
    localparam int S_OC = 5, S_UD = 6, S_NOSTOP = 7, S_PEND = 8;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    elevator_req_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1s        (tick_1s),
        .floor_btn      (floor_btn),
        .reset_clock    (reset_clock),
        .Delay          (Delay),
        .FR_Delay       (FR_Delay),
        .Actual_Stage   (Actual_Stage),
        .UD_Answer      (UD_Answer),
        .STOP           (STOP),
        .actual_clock   (actual_clock),
        .DoneResetClock (DoneResetClock),
        .DoneDelay      (DoneDelay),
        .DoneFRDelay    (DoneFRDelay),
        .next_stage     (next_stage),
        .OC_Request     (OC_Request),
        .UD_Request     (UD_Request),
        .NO_STOP        (NO_STOP),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            S_CLK:    return {4'd0, actual_clock};
            S_DRC:    return {7'd0, DoneResetClock};
            S_DD:     return {7'd0, DoneDelay};
            S_DFR:    return {7'd0, DoneFRDelay};
            S_NS:     return {5'd0, next_stage};
            S_OC:     return {7'd0, OC_Request};
            S_UD:     return {7'd0, UD_Request};
            S_NOSTOP: return {7'd0, NO_STOP};
            S_PEND:   return {4'd0, pending};
            default:  return 8'hxx;
        endcase
    endfunction

    // inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.sel);
            n_cmp++;
            assert (o === e.val)
            else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b0; tick_1s = 1'b0; floor_btn = 4'b0000; reset_clock = 1'b0;
        Delay = 1'b0; FR_Delay = 1'b0; Actual_Stage = 2'd0; UD_Answer = 1'b1; STOP = 1'b1;

        // reset state
        cyc(2);
        push("rst_clock", S_CLK, 8'd0);   push("rst_pend", S_PEND, 8'd0);
        push("rst_ns", S_NS, 8'd0);       push("rst_oc", S_OC, 8'd1);
        push("rst_ud", S_UD, 8'd1);       push("rst_nostop", S_NOSTOP, 8'd0);
        push("rst_drc", S_DRC, 8'd0);     push("rst_dd", S_DD, 8'd0);
        push("rst_dfr", S_DFR, 8'd0);
        drain();
        reset = 1'b1;

        // three seconds, then clear held 3 cycles with ticks
        tick_1s = 1'b1;
        push("cnt3", S_CLK, 8'd3);
        cyc(3); drain();
        reset_clock = 1'b1;
        push("clr_pulse", S_DRC, 8'd1);   push("clr_zero", S_CLK, 8'd0);
        cyc(1); drain();
        push("clr_once2", S_DRC, 8'd0);
        cyc(1); drain();
        push("clr_once3", S_DRC, 8'd0);   push("clr_wins", S_CLK, 8'd0);
        cyc(1); drain();
        reset_clock = 1'b0;

        // saturation over 20 ticks
        push("cnt14", S_CLK, 8'd14);
        cyc(14); drain();
        push("sat15", S_CLK, 8'd15);
        cyc(6); drain();
        tick_1s = 1'b0;
        reset_clock = 1'b1;
        push("clr_again", S_DRC, 8'd1);
        cyc(1); drain();
        reset_clock = 1'b0;
        cyc(1);

        // call to floor 2 from floor 0 while idle
        floor_btn = 4'b0100;
        push("call_pend", S_PEND, 8'h4);  push("call_nostop0", S_NOSTOP, 8'd0);
        cyc(1); drain();
        floor_btn = 4'b0000;
        push("disp_ud", S_UD, 8'd1);      push("disp_nostop", S_NOSTOP, 8'd1);
        push("disp_oc", S_OC, 8'd0);
        cyc(1); drain();
        push("disp_hold", S_NOSTOP, 8'd1);
        cyc(2); drain();
        STOP = 1'b0;
        push("move_nostop", S_NOSTOP, 8'd0); push("move_ns", S_NS, 8'd0);
        cyc(1); drain();

        // arrival at floor 1 with no call there
        Actual_Stage = 2'd1; Delay = 1'b1;
        push("pass_dd", S_DD, 8'd1);      push("pass_oc", S_OC, 8'd0);
        push("pass_pend", S_PEND, 8'h4);
        cyc(1); drain();
        push("pass_dd_once", S_DD, 8'd0);
        cyc(1); drain();
        Delay = 1'b0;

        // more calls, then arrival at floor 2
        floor_btn = 4'b1001;
        push("more_pend", S_PEND, 8'hD);
        cyc(1); drain();
        floor_btn = 4'b0000;
        Actual_Stage = 2'd2; Delay = 1'b1;
        push("arr_dd", S_DD, 8'd1);       push("arr_oc", S_OC, 8'd1);
        push("arr_pend", S_PEND, 8'h9);
        cyc(1); drain();
        Delay = 1'b0;
        tick_1s = 1'b1;
        cyc(4);
        tick_1s = 1'b0;
        push("door_clock", S_CLK, 8'd4);  push("door_ns_up", S_NS, 8'h7);
        cyc(1); drain();
        FR_Delay = 1'b1;
        push("fr_ack", S_DFR, 8'd1);      push("fr_ns", S_NS, 8'h0);
        push("fr_pend", S_PEND, 8'h9);
        cyc(1); drain();
        push("fr_ack_once", S_DFR, 8'd0);
        cyc(1); drain();
        FR_Delay = 1'b0;
        UD_Answer = 1'b0;
        push("door_ns_down", S_NS, 8'h4);
        cyc(1); drain();
        UD_Answer = 1'b1;

        // close door, restart upward toward floor 3
        STOP = 1'b1;
        push("door_idle_oc", S_OC, 8'd1);
        cyc(1); drain();
        push("redisp_nostop", S_NOSTOP, 8'd1); push("redisp_ud", S_UD, 8'd1);
        cyc(1); drain();

        // reset mid-dispatch overrides a simultaneous button press
        reset = 1'b0; floor_btn = 4'b1111;
        push("mid_rst_nostop", S_NOSTOP, 8'd0); push("mid_rst_oc", S_OC, 8'd1);
        push("mid_rst_pend", S_PEND, 8'd0);     push("mid_rst_ns", S_NS, 8'd0);
        cyc(1); drain();
        reset = 1'b1; floor_btn = 4'b0000;

        // call at the current floor is absorbed while idle
        Actual_Stage = 2'd3;
        floor_btn = 4'b1000;
        cyc(1);
        floor_btn = 4'b0000;
        push("here_pend", S_PEND, 8'd0);  push("here_oc", S_OC, 8'd1);
        push("here_nostop", S_NOSTOP, 8'd0);
        cyc(1); drain();

        // call below the cabin restarts downward
        floor_btn = 4'b0001;
        cyc(1);
        floor_btn = 4'b0000;
        push("down_ud", S_UD, 8'd0);      push("down_nostop", S_NOSTOP, 8'd1);
        cyc(1); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
